// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC engine: folds a byte stream into an LFSR MSB first, one bit per cycle,
// and presents the final CRC on a valid/ready handshake at end of frame.
module crc16_serial_engine #(
  parameter int unsigned       pCRC_W  = 16,
  parameter logic [pCRC_W-1:0] pPOLY   = pCRC_W'(16'h1021),
  parameter logic [pCRC_W-1:0] pINIT   = pCRC_W'(16'hFFFF),
  parameter logic [pCRC_W-1:0] pXOROUT = pCRC_W'(16'h0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              abort,
  output logic [pCRC_W-1:0] crc_out,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic              busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [pCRC_W-1:0]   crc_q, crc_d;
  logic [BYTE_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                fb;

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    fb      = crc_q[pCRC_W-1] ^ sh_q[BYTE_W-1];

    if (abort) begin
      state_d = IDLE;
      crc_d   = pINIT;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_d    = in_data;
            last_d  = in_last;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          crc_d = {crc_q[pCRC_W-2:0], 1'b0} ^ (fb ? pPOLY : '0);
          sh_d  = {sh_q[BYTE_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = last_q ? DONE : IDLE;
          end
        end
        DONE: begin
          if (crc_ready) begin
            crc_d   = pINIT;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      crc_q     <= pINIT;
      sh_q      <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      in_ready  <= 1'b1;
      crc_valid <= 1'b0;
      busy      <= 1'b0;
      crc_out   <= pINIT ^ pXOROUT;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      in_ready  <= (state_d == IDLE);
      crc_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      crc_out   <= crc_d ^ pXOROUT;
    end
  end

endmodule

// File: tb/tb_crc16_serial_engine.sv
// Self-checking bench for crc16_serial_engine: scoreboarded CRC results plus
// handshake timing, backpressure, abort and reset scenarios.
module tb_crc16_serial_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic [15:0] crc_out;
  logic        crc_valid;
  logic        crc_ready = 1'b0;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  frm[$];
  int unsigned acc_cyc[$];

  crc16_serial_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .abort     (abort),
    .crc_out   (crc_out),
    .crc_valid (crc_valid),
    .crc_ready (crc_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-at-a-time CRC-16/CCITT-FALSE reference over frm.
  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (frm[i]) begin
      c = c ^ {frm[i], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_digits();
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
  endtask

  task automatic load_byte(input logic [7:0] b);
    frm.delete();
    frm.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit drop);
    int waited;
    waited   = 0;
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    acc_cyc.push_back(cyc);
    if (drop) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_frame(input bit hold_valid);
    acc_cyc.delete();
    foreach (frm[i]) send_byte(frm[i], (i == frm.size() - 1), !hold_valid);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    int waited;
    waited = 0;
    while (crc_valid !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    ok = (crc_valid === 1'b1);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_valid_timeout: crc_valid=%0b required 1", name, crc_valid);
    end
  endtask

  // Pops the scoreboard, compares crc_out, completes the handshake.
  task automatic wait_crc(input string name, input bit hold_ready);
    bit          ok;
    logic [15:0] exp;
    wait_valid(name, ok);
    if (!ok) return;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: crc_out=%h required no output", name, crc_out);
    end else begin
      exp = exp_q.pop_front();
      if (crc_out !== exp) begin
        n_fail++;
        $display("FAIL %s_crc: crc_out=%h required %h", name, crc_out, exp);
      end
    end
    crc_ready = 1'b1;
    step();
    crc_ready = hold_ready;
    n_tests++;
    if (crc_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: crc_valid=%0b in_ready=%0b required 0 1", name, crc_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: %0b required 1", in_ready); end
    n_tests++;
    if (crc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_crc_valid: %0b required 0", crc_valid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %0b required 0", busy); end
    n_tests++;
    if (crc_out !== 16'hFFFF) begin n_fail++; $display("FAIL reset_crc_out: %h required ffff", crc_out); end
  endtask

  task automatic test_single_zero();
    bit early;
    early = 1'b0;
    load_byte(8'h00);
    exp_q.push_back(16'hE1F0);
    send_byte(8'h00, 1'b1, 1'b1);
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_shift_state: busy=%0b in_ready=%0b required 1 0", busy, in_ready);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      if (crc_valid !== 1'b0) early = 1'b1;
    end
    step();
    n_tests++;
    if (early || crc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid_timing: early=%0b crc_valid_after_T+8=%0b required 0 1", early, crc_valid);
    end
    wait_crc("single_zero", 1'b0);
  endtask

  task automatic test_stream();
    bit gaps_ok;
    gaps_ok = 1'b1;
    load_digits();
    exp_q.push_back(crc_ref());
    send_frame(1'b1);
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] != 9) gaps_ok = 1'b0;
    n_tests++;
    if (!gaps_ok || acc_cyc.size() != 9) begin
      n_fail++;
      $display("FAIL stream_rate: accepts=%0d first_gap=%0d required 9 accepts every 9 cycles",
               acc_cyc.size(), (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : 0);
    end
    n_tests++;
    if (exp_q[0] !== 16'h29B1) begin
      n_fail++;
      $display("FAIL stream_model: model=%h required 29b1", exp_q[0]);
    end
    wait_crc("stream", 1'b0);
  endtask

  task automatic test_back_to_back();
    load_digits();
    exp_q.push_back(16'h29B1);
    send_frame(1'b0);
    wait_crc("b2b_first", 1'b0);
    load_byte(8'h00);
    exp_q.push_back(16'hE1F0);
    send_frame(1'b0);
    wait_crc("b2b_second", 1'b0);
  endtask

  task automatic test_backpressure();
    bit ok;
    load_digits();
    exp_q.push_back(16'h29B1);
    send_frame(1'b0);
    wait_valid("bp", ok);
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    in_last   = 1'b1;
    crc_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if (crc_valid !== 1'b1 || crc_out !== 16'h29B1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%0b crc=%h ready=%0b busy=%0b required 1 29b1 0 1",
                 k, crc_valid, crc_out, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_crc("bp", 1'b0);
    step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept: busy=%0b required 0", busy); end
  endtask

  task automatic test_abort();
    bit ok;
    send_byte(8'h31, 1'b0, 1'b1);
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_shift: busy=%0b in_ready=%0b required 0 1", busy, in_ready);
    end
    load_digits();
    exp_q.push_back(16'h29B1);
    send_frame(1'b0);
    wait_crc("abort_after", 1'b0);
    // A byte presented together with abort must be dropped.
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle_accept: busy=%0b in_ready=%0b required 0 1", busy, in_ready);
    end
    load_byte(8'h00);
    send_frame(1'b0);
    wait_valid("abort_done", ok);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_tests++;
    if (crc_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done_discard: valid=%0b ready=%0b busy=%0b required 0 1 0", crc_valid, in_ready, busy);
    end
    load_digits();
    exp_q.push_back(16'h29B1);
    send_frame(1'b0);
    wait_crc("abort_done_after", 1'b0);
  endtask

  task automatic test_rst_in_done();
    bit ok;
    load_digits();
    send_frame(1'b0);
    wait_valid("rst_done", ok);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (crc_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_done_state: valid=%0b ready=%0b busy=%0b required 0 1 0", crc_valid, in_ready, busy);
    end
    load_byte(8'h00);
    exp_q.push_back(16'hE1F0);
    send_frame(1'b0);
    wait_crc("rst_after", 1'b0);
  endtask

  task automatic test_random();
    crc_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      frm.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) frm.push_back(8'($urandom_range(0, 255)));
      exp_q.push_back(crc_ref());
      send_frame(f[0]);
      wait_crc("random", 1'b1);
    end
    crc_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_rst_in_done();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
